// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, FSM state encoding and flag layout.
// Imported by the ALU top and its flag-generation sub-block.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NEG  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_NOP  = 3'b101;
  localparam logic [2:0] OP_RSV  = 3'b110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit positions match the packed struct below, so a flag bus can be indexed either way.
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_W     = 4;

  typedef struct packed {
    logic ovf;
    logic carry;
    logic neg;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_flags.sv
// Carry and signed-overflow generation for every opcode, shared by the
// single-cycle path and the multiplier completion step.
module alu_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH:0]   sum_i,
  input  logic [WIDTH:0]   diff_i,
  input  logic             mulHiNz_i,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signA;
  logic signB;

  assign signA = a_i[WIDTH-1];
  assign signB = b_i[WIDTH-1];

  // diff_i is B-A computed one bit wider, so its top bit is the borrow.
  always_comb begin
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    case (op_i)
      OP_ADD: begin
        carry_o = sum_i[WIDTH];
        ovf_o   = (signA == signB) && (sum_i[WIDTH-1] != signB);
      end
      OP_SUB: begin
        carry_o = ~diff_i[WIDTH];
        ovf_o   = (signA != signB) && (diff_i[WIDTH-1] != signB);
      end
      OP_NEG: begin
        ovf_o = (b_i == MOST_NEG);
      end
      OP_MUL: begin
        carry_o = mulHiNz_i;
      end
      default: begin
        carry_o = 1'b0;
        ovf_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and a bit-serial
// shift-add multiplier; single-cycle ops complete in one cycle, MUL in WIDTH.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  alu_flags_t         flags_q, flags_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               opIsMul;
  logic [2:0]         opEff;
  logic [2:0]         flagsOp;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   singleResult;
  logic [2*WIDTH-1:0] mulAddend;
  logic [2*WIDTH-1:0] product;
  logic               lastIter;
  logic               flagCarry;
  logic               flagOvf;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_MUL);
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign carry     = flags_q.carry;
  assign ovf       = flags_q.ovf;

  // With the multiplier compiled out, MUL is folded onto the reserved encoding.
  assign opIsMul = MUL_EN && (op == OP_MUL);
  assign opEff   = ((op == OP_MUL) && !MUL_EN) ? OP_RSV : op;

  assign sum  = {1'b0, b} + {1'b0, a};
  assign diff = {1'b0, b} - {1'b0, a};

  assign mulAddend = mplier_q[0] ? mcand_q : '0;
  assign product   = acc_q + mulAddend;
  assign lastIter  = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    singleResult = '0;
    case (opEff)
      OP_ADD:  singleResult = sum[WIDTH-1:0];
      OP_SUB:  singleResult = diff[WIDTH-1:0];
      OP_NEG:  singleResult = '0 - b;
      OP_PASS: singleResult = a;
      default: singleResult = '0;
    endcase
  end

  assign flagsOp = (state_q == ST_MUL) ? OP_MUL : opEff;

  alu_flags #(.WIDTH(WIDTH)) u_flags (
    .op_i      (flagsOp),
    .a_i       (a),
    .b_i       (b),
    .sum_i     (sum),
    .diff_i    (diff),
    .mulHiNz_i (|product[2*WIDTH-1:WIDTH]),
    .carry_o   (flagCarry),
    .ovf_o     (flagOvf)
  );

  // Result and flags only move on an accept or on multiplier completion,
  // which keeps them stable while a DONE result waits for out_ready.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_MUL: begin
        acc_d    = product;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (lastIter) begin
          state_d       = ST_DONE;
          result_d      = product[WIDTH-1:0];
          flags_d.zero  = (product[WIDTH-1:0] == '0);
          flags_d.neg   = product[WIDTH-1];
          flags_d.carry = flagCarry;
          flags_d.ovf   = flagOvf;
        end
      end
      default: begin
        if (accept) begin
          if (opIsMul) begin
            state_d  = ST_MUL;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, b};
            mplier_d = a;
            cnt_d    = '0;
          end else begin
            state_d       = ST_DONE;
            result_d      = singleResult;
            flags_d.zero  = (singleResult == '0);
            flags_d.neg   = singleResult[WIDTH-1];
            flags_d.carry = flagCarry;
            flags_d.ovf   = flagOvf;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '{ovf: 1'b0, carry: 1'b0, neg: 1'b0, zero: 1'b1};
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe (WIDTH=32): handshake, latency, flags,
// multiplier timing, output hold and asynchronous reset during a multiply.
module tb_alu_pipe;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          neg;
  logic          carry;
  logic          ovf;
  logic          busy;

  int testCount;
  int failCount;

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic v);
    op       = o;
    a        = av;
    b        = bv;
    in_valid = v;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Packed view {out_valid, result, zero, neg, carry, ovf} against the expected values.
  task automatic checkResult(input string tag, input logic [W-1:0] expResult,
                             input logic [3:0] expFlags);
    checkOutput(tag, {27'd0, out_valid, result, zero, neg, carry, ovf},
                {27'd0, 1'b1, expResult, expFlags});
  endtask

  initial begin
    int mulOk;
    testCount = 0;
    failCount = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(3'b000, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    checkOutput("reset_state", {58'd0, out_valid, busy, zero, neg, carry, ovf},
                {58'd0, 6'b001000});
    checkOutput("reset_result", {32'd0, result}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", {63'd0, in_ready}, 64'd1);

    // ADD with carry out and zero result
    applyStimulus(3'b000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
    stepCycle();
    checkResult("add_carry", 32'h0000_0000, 4'b1010);

    // SUB with borrow, back-to-back with the previous result
    applyStimulus(3'b001, 32'd5, 32'd3, 1'b1);
    stepCycle();
    checkResult("sub_borrow", 32'hFFFF_FFFE, 4'b0100);

    applyStimulus(3'b010, 32'd0, 32'h8000_0000, 1'b1);
    stepCycle();
    checkResult("neg_mostneg", 32'h8000_0000, 4'b0101);

    applyStimulus(3'b001, 32'd5, 32'd5, 1'b1);
    stepCycle();
    checkResult("sub_equal", 32'h0000_0000, 4'b1010);

    applyStimulus(3'b000, 32'h7FFF_FFFF, 32'd1, 1'b1);
    stepCycle();
    checkResult("add_sovf", 32'h8000_0000, 4'b0101);

    applyStimulus(3'b110, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    stepCycle();
    checkResult("reserved_op", 32'h0000_0000, 4'b1000);

    applyStimulus(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    stepCycle();
    checkResult("nop_op", 32'h0000_0000, 4'b1000);

    // MUL 0x10000 * 0x30000: low half zero, upper half nonzero
    applyStimulus(3'b100, 32'h0001_0000, 32'h0003_0000, 1'b1);
    stepCycle();
    applyStimulus(3'b000, '0, '0, 1'b0);
    mulOk = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy === 1'b1 && in_ready === 1'b0 && out_valid === 1'b0) mulOk++;
      stepCycle();
    end
    checkOutput("mul_busy_cycles", 64'(mulOk), 64'd32);
    checkResult("mul_hi_carry", 32'h0000_0000, 4'b1010);
    checkOutput("mul_busy_clear", {63'd0, busy}, 64'd0);

    applyStimulus(3'b100, 32'd7, 32'd6, 1'b1);
    stepCycle();
    applyStimulus(3'b000, '0, '0, 1'b0);
    for (int i = 0; i < 31; i++) stepCycle();
    checkOutput("mul_not_early", {63'd0, out_valid}, 64'd0);
    stepCycle();
    checkResult("mul_small", 32'd42, 4'b0000);

    // Output hold with out_ready low
    stepCycle();
    out_ready = 1'b0;
    applyStimulus(3'b000, 32'd2, 32'd3, 1'b1);
    stepCycle();
    applyStimulus(3'b000, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkResult("hold_result", 32'd5, 4'b0000);
      checkOutput("hold_not_ready", {63'd0, in_ready}, 64'd0);
      stepCycle();
    end
    out_ready = 1'b1;
    applyStimulus(3'b011, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1);
    stepCycle();
    checkResult("pass_after_hold", 32'h0000_1234, 4'b0000);

    // Back-to-back stream of 8 ADDs, one result per cycle in order
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'b000, 32'(i), 32'd100, 1'b1);
      stepCycle();
      checkResult("stream_add", 32'd100 + 32'(i), 4'b0000);
    end
    applyStimulus(3'b000, '0, '0, 1'b0);

    // Reset asserted ten cycles into a multiply
    applyStimulus(3'b100, 32'd7, 32'd6, 1'b1);
    stepCycle();
    applyStimulus(3'b000, '0, '0, 1'b0);
    for (int i = 0; i < 9; i++) stepCycle();
    checkOutput("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_state", {58'd0, out_valid, busy, zero, neg, carry, ovf},
                {58'd0, 6'b001000});
    checkOutput("mid_reset_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready", {62'd0, in_ready, busy}, 64'd2);
    applyStimulus(3'b000, 32'd10, 32'd20, 1'b1);
    stepCycle();
    checkResult("post_reset_add", 32'd30, 4'b0000);
    applyStimulus(3'b000, '0, '0, 1'b0);
    stepCycle();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the datapath's single-cycle combinational ALU.
- Adds a valid/ready handshake on input and output, a multi-cycle shift-add multiplier, and carry and overflow flags alongside zero and negative.
- Sits between the register-file read stage and write-back. The controller issues an operation and stalls on in_ready/out_valid instead of assuming single-cycle completion.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL behaves as reserved.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  3  opcode (see Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].
- carry  out  1  carry / no-borrow / unsigned-overflow flag.
- ovf  out  1  signed overflow.
- busy  out  1  multiply in progress.

Behaviour:
- Reset:
  - Asserting rst_n=0 at any time, including mid-multiply, immediately forces state=IDLE.
  - Forces result=0, zero=1, neg=0, carry=0, ovf=0, out_valid=0, busy=0.
  - Clears the iteration counter and operand registers.
  - No pending operation survives reset.
- Opcodes (B is the left operand):
  - 000 ADD: B+A.
  - 001 SUB: B-A.
  - 010 NEG: -B.
  - 011 PASS: A.
  - 100 MUL: low WIDTH bits of unsigned B*A.
  - 101 NOP: 0.
  - 110, 111 reserved: 0, all flags except zero cleared.
- FSM states: IDLE, MUL, DONE.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Output transfer occurs when out_valid && out_ready.
  - out_valid=1 exactly in DONE.
  - result and flags are stable while out_valid && !out_ready.
- Single-cycle ops (all opcodes except MUL with MUL_EN=1):
  - Accept -> result/flags registered on that edge -> DONE next cycle.
  - Latency 1 cycle.
- Back-to-back: in DONE with out_ready=1 and in_valid=1, the new op is accepted on the same edge the old result transfers. Throughput is 1 op/cycle for single-cycle ops.
- DONE with out_ready=1 and in_valid=0 -> IDLE.
- MUL sequence:
  - Accept latches a, b and clears a 2*WIDTH accumulator, then goes to MUL with busy=1.
  - Each cycle processes one multiplier bit (LSB first).
  - The counter ($clog2(WIDTH+1) bits) counts WIDTH iterations.
  - After the WIDTH-th iteration the block goes to DONE.
  - Latency from accept to out_valid is WIDTH+1 cycles.
  - in_ready=0 and busy=1 throughout MUL.
- Operands are captured at accept; a/b/op may change freely afterwards.
- Flags are computed from the final WIDTH-bit result, except where noted:
  - zero = (result==0).
  - neg = result MSB.
  - ADD: carry = carry-out of the WIDTH-bit add; ovf = signs of A and B equal and the result sign differs.
  - SUB: carry = 1 iff B >= A unsigned (no borrow); ovf = signs of B and A differ and the result sign differs from B.
  - NEG: carry=0; ovf=1 iff B == 1 followed by WIDTH-1 zeros (most-negative value).
  - PASS, NOP: carry=0, ovf=0.
  - MUL: carry = OR of upper WIDTH product bits; ovf=0.
- Wrap-around: all arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams (OP_ADD, OP_SUB, OP_NEG, OP_PASS, OP_MUL, OP_NOP).
  - FSM state encoding (IDLE, MUL, DONE).
  - Flag bit indices for any packed flag bus consumers build.
- One sub-module: alu_flags, a combinational block taking op, a, b and raw sum/diff and producing carry/ovf. It is reused by the single-cycle path and the MUL completion step.
- The shift-add multiplier stays inline; it is controlled by the FSM.

Test Plan (WIDTH=32):
1. ADD, a=0x0000_0001, b=0xFFFF_FFFF -> one cycle later out_valid=1, result=0, zero=1, carry=1, ovf=0.
2. SUB, a=5, b=3 -> result=0xFFFF_FFFE, neg=1, carry=0, ovf=0. Then NEG with b=0x8000_0000 -> result=0x8000_0000, ovf=1.
3. MUL, a=0x0001_0000, b=0x0003_0000 -> in_ready=0 and busy=1 for 32 cycles, out_valid on cycle 33, result=0, carry=1, zero=1. Repeat with a=7, b=6 -> result=42, carry=0.
4. Hold with out_ready=0 for 5 cycles after an ADD -> result/flags unchanged and in_ready=0. Then raise out_ready with in_valid=1 (PASS a=0x1234) -> next cycle result=0x1234.
5. Back-to-back ADD stream of 8 ops with out_ready=1 constantly -> 8 results on 8 consecutive cycles, in order.
6. Pull rst_n low 10 cycles into a MUL -> outputs immediately at reset values. After release, in_ready=1 and a new ADD completes normally.
